// File: rtl/pc_seq_pkg.sv
// Shared definitions for the next-PC sequencer: FSM encoding, exception
// cause codes, default boot/handler addresses and a target alignment helper.
package pc_seq_pkg;

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam logic [31:0] DEF_RESET_PC   = 32'h0040_0000;
   localparam logic [31:0] DEF_EXC_VECTOR = 32'h0040_0004;

   // Instruction fetches must be word aligned; anything else raises AdEL.
   function automatic logic misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/pc_exc_regs.sv
// EPC / cause / EXL register bank. Capture saves the faulting PC only on
// first entry so a nested exception keeps the original return address.
module pc_exc_regs
   import pc_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        capture_i,
   input  logic [4:0]  code_i,
   input  logic [31:0] pc_i,
   input  logic        clear_i,
   output logic [31:0] epc_o,
   output logic [4:0]  cause_o,
   output logic        exl_o
);

   logic [31:0] epc_q;
   logic [4:0]  cause_q;
   logic        exl_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         epc_q   <= '0;
         cause_q <= '0;
         exl_q   <= 1'b0;
      end else if (capture_i) begin
         cause_q <= code_i;
         if (!exl_q) begin
            epc_q <= pc_i;
            exl_q <= 1'b1;
         end
      end else if (clear_i) begin
         exl_q <= 1'b0;
      end
   end

   assign epc_o   = epc_q;
   assign cause_o = cause_q;
   assign exl_o   = exl_q;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: picks the PC register's next value by fixed priority,
// drives its enable and flush, and runs the BOOT/RUN/HALT control FSM.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
   parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] cur_pc,
   input  logic        stall,
   input  logic        halt_req,
   input  logic        resume,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        jr,
   input  logic [31:0] jr_target,
   input  logic        exc_req,
   input  logic [4:0]  exc_code,
   input  logic        eret,
   output logic [31:0] pc_next,
   output logic        pc_ena,
   output logic        flush,
   output logic [31:0] epc,
   output logic [4:0]  cause,
   output logic        exl,
   output logic [1:0]  state_o
);

   logic [1:0]  state_q, state_d;
   logic        ctrlValid;
   logic [31:0] ctrlTarget;
   logic        trapHit;
   logic        excAny;
   logic        excTake;
   logic        eretTake;
   logic        redirect;
   logic [4:0]  excCode;

   // The trap only inspects the control-flow target that would actually win.
   always_comb begin
      ctrlValid  = jr | jump | br_taken;
      ctrlTarget = jr ? jr_target : (jump ? jump_target : br_target);
      trapHit    = ctrlValid && misaligned(ctrlTarget);
      excAny     = exc_req | trapHit;
      excTake    = (state_q == ST_RUN) && excAny;
      excCode    = exc_req ? exc_code : EXC_ADEL;
   end

   // Exceptions ignore stall; every other redirect waits for the stall to drop.
   always_comb begin
      pc_next  = cur_pc;
      pc_ena   = 1'b0;
      flush    = 1'b0;
      redirect = 1'b0;
      eretTake = 1'b0;
      case (state_q)
         ST_BOOT: pc_next = RESET_PC;
         ST_RUN: begin
            if (excAny) begin
               pc_next  = EXC_VECTOR;
               redirect = 1'b1;
            end else if (eret) begin
               pc_next  = epc;
               redirect = 1'b1;
            end else if (ctrlValid) begin
               pc_next  = ctrlTarget;
               redirect = 1'b1;
            end else begin
               pc_next  = cur_pc + 32'd4;
            end
            pc_ena   = excAny | ~stall;
            flush    = pc_ena & redirect;
            eretTake = eret & ~excAny & ~stall;
         end
         ST_HALT: pc_next = cur_pc;
         default: pc_next = RESET_PC;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN:  if (halt_req && !excAny) state_d = ST_HALT;
         ST_HALT: if (resume) state_d = ST_RUN;
         default: state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   pc_exc_regs u_exc_regs (
      .clk       (clk),
      .rst_n     (rst_n),
      .capture_i (excTake),
      .code_i    (excCode),
      .pc_i      (cur_pc),
      .clear_i   (eretTake),
      .epc_o     (epc),
      .cause_o   (cause),
      .exl_o     (exl)
   );

   assign state_o = state_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the single-cycle MIPS core. Each cycle it chooses the address the PC register loads and drives that register's enable. Sources are sequential fetch, branch, jump, register jump, exception vector and exception return. It also holds the EPC, cause and EXL exception state, so the PC register itself stays a plain loadable register.

## Interface
- RESET_PC, 32'h00400000, boot address; must equal the PC register's reset value
- EXC_VECTOR, 32'h00400004, exception handler entry
- clk  in  1  system clock; state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- cur_pc  in  32  current PC register output
- stall  in  1  hold PC (hazard or memory wait)
- halt_req  in  1  enter HALT (break instruction)
- resume  in  1  leave HALT
- br_taken  in  1  conditional branch resolved taken
- br_target  in  32  branch target
- jump  in  1  j/jal
- jump_target  in  32  jump target
- jr  in  1  jr/jalr
- jr_target  in  32  register target
- exc_req  in  1  synchronous exception (syscall, overflow, illegal op)
- exc_code  in  5  cause code for exc_req
- eret  in  1  exception return
- pc_next  out  32  address for the PC register input
- pc_ena  out  1  PC register enable
- flush  out  1  squash the in-flight instruction
- epc  out  32  saved exception PC
- cause  out  5  last exception code
- exl  out  1  exception level, 1 while in handler
- state_o  out  2  FSM state, for debug

## Operation
- FSM states: BOOT=0, RUN=1, HALT=2.
  - BOOT lasts exactly one cycle after reset release, then goes to RUN.
  - RUN goes to HALT on halt_req when no exception is pending.
  - HALT goes to RUN on resume.
- In BOOT: pc_next=RESET_PC, pc_ena=0.
- In HALT: pc_ena=0, pc_next=cur_pc, all requests ignored, flush=0.
- In RUN, pc_next is chosen by fixed priority (highest first):
  1. exc_req: EXC_VECTOR
  2. misaligned-target trap: EXC_VECTOR
  3. eret: epc
  4. jr: jr_target
  5. jump: jump_target
  6. br_taken: br_target
  7. otherwise: cur_pc+4, modulo 2^32 (wraps)
- Misaligned-target trap:
  - Fires when the selected jr, jump or branch target has bits [1:0] != 0.
  - Treated as exception code 5'd4 (AdEL), with EPC capture as for exc_req.
- pc_ena in RUN: 1 unless stall=1. An exception or trap overrides stall and forces pc_ena=1.
- flush=1 on any non-sequential redirect that loads (pc_ena=1): exc, trap, eret, jr, jump, branch.
- Exception entry, on the rising edge:
  - If exl=0: epc<=cur_pc, cause<=code, exl<=1.
  - If exl=1 (nested): the vector is still taken and cause is updated, but epc is not overwritten.
- eret: exl<=0 on the edge, epc retained. eret while exl=0 still returns to epc.
- halt_req and an exception in the same cycle: the exception wins, and HALT is entered on a later request.
- A stalled branch, jump or eret produces no state change; the requester holds its request.

## Timing
- pc_next, pc_ena and flush are combinational from the current state and inputs, with no added latency.
- epc, cause, exl and state are registered on the clk rising edge.
- The PC register samples on the falling edge of the same clock. pc_next is therefore stable half a cycle after the rising edge, and is consumed in the same cycle.
- Reset values: state=BOOT, epc=0, cause=0, exl=0. During reset: pc_ena=0, flush=0, pc_next=RESET_PC.
- Reset asserted mid-operation clears all state immediately (asynchronous) and discards any pending redirect.
- cur_pc=32'hFFFFFFFC with no redirect gives pc_next=32'h00000000.

## Structure
- Shared package pc_seq_pkg holds:
  - FSM state encoding (BOOT, RUN, HALT)
  - exception code constants (EXC_ADEL=4, EXC_SYS=8, EXC_OV=12)
  - default RESET_PC and EXC_VECTOR
- One sub-module, pc_exc_regs: the EPC, cause and EXL register bank with capture/clear controls. Next-PC mux and FSM stay in the top.

## Test plan
- Reset release → one BOOT cycle with pc_ena=0 and pc_next=32'h00400000; next cycle RUN, pc_next=cur_pc+4, pc_ena=1.
- jump=1 with br_taken=1, jump_target=32'h00400100 → pc_next=32'h00400100, flush=1. Repeat with stall=1 → pc_ena=0, no state change.
- exc_req, code 12, at cur_pc=32'h00400020, stall=1 → pc_next=32'h00400004, pc_ena=1, then epc=32'h00400020, cause=12, exl=1. Nested exc_req code 8 → epc unchanged, cause=8. eret → pc_next=32'h00400020, exl=0.
- jr_target=32'h00400102 → pc_next=EXC_VECTOR, cause=4, epc=cur_pc.
- halt_req → HALT, pc_ena=0 with jumps ignored; resume → RUN. halt_req together with exc_req → vector taken, state stays RUN.
- rst_n asserted mid-cycle with exl=1 → immediate epc=0, cause=0, exl=0, state=BOOT. cur_pc=32'hFFFFFFFC → pc_next=0.
